// File: rtl/alu_writeback_seq_if.sv
// alu_writeback_seq_if: decoder/ALU-side bundle for the writeback sequencer
interface alu_writeback_seq_if #(
  parameter int BIT_COUNT      = 8,
  parameter int ALU_FLAG_COUNT = 2
);
  logic                      insn_valid;
  logic                      insn_ready;
  logic [2:0]                insn_rd;
  logic                      insn_wb_en;
  logic                      insn_flag_we;
  logic [1:0]                insn_br_op;
  logic [BIT_COUNT-1:0]      insn_br_target;
  logic [2:0]                rs_sel;
  logic [BIT_COUNT-1:0]      alu_c;
  logic [ALU_FLAG_COUNT-1:0] alu_flags;
  logic [BIT_COUNT-1:0]      reg_acc;
  logic [BIT_COUNT-1:0]      reg_b;
  logic [BIT_COUNT-1:0]      pc;
  logic [ALU_FLAG_COUNT-1:0] flags;
  logic                      phase_exec;
  logic                      phase_pc;
  logic [BIT_COUNT-1:0]      pc_b_operand;
  logic                      pc_take_branch;
  logic                      retire;
  modport master (
    output insn_valid, insn_rd, insn_wb_en, insn_flag_we, insn_br_op, insn_br_target,
    output rs_sel, alu_c, alu_flags,
    input  insn_ready, reg_acc, reg_b, pc, flags, phase_exec, phase_pc,
    input  pc_b_operand, pc_take_branch, retire
  );
  modport slave (
    input  insn_valid, insn_rd, insn_wb_en, insn_flag_we, insn_br_op, insn_br_target,
    input  rs_sel, alu_c, alu_flags,
    output insn_ready, reg_acc, reg_b, pc, flags, phase_exec, phase_pc,
    output pc_b_operand, pc_take_branch, retire
  );
endinterface

// File: rtl/alu_writeback_seq.sv
// alu_writeback_seq: three-phase sequencer that writes ALU results back and steps the pc
module alu_writeback_seq #(
  parameter int BIT_COUNT      = 8,
  parameter int REG_COUNT      = 8,
  parameter int ALU_FLAG_COUNT = 2,
  parameter int ALU_FLAG_EQ    = 0,
  parameter int ALU_FLAG_GT    = 1
) (
  input logic               clk,
  input logic               rst,
  alu_writeback_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, PCUPD} state_t;
  state_t                    state_q, state_d;
  logic                      ready_q, exec_q, pcph_q;
  logic [2:0]                rd_q;
  logic                      wb_en_q, flag_we_q;
  logic [1:0]                br_op_q;
  logic [BIT_COUNT-1:0]      br_target_q;
  logic [BIT_COUNT-1:0]      regs_q [REG_COUNT];
  logic [BIT_COUNT-1:0]      pc_q, pc_d;
  logic [ALU_FLAG_COUNT-1:0] flags_q, flags_d;
  logic                      accept, taken;
  assign accept  = (state_q == IDLE) && bus.insn_valid;
  assign state_d = state_q == IDLE ? (bus.insn_valid ? EXEC : IDLE) : state_q == EXEC ? PCUPD : IDLE;
  assign flags_d = (state_q == EXEC && flag_we_q) ? bus.alu_flags : flags_q;
  assign pc_d    = (state_q == PCUPD) ? bus.alu_c : pc_q;
  // Phase outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      exec_q  <= 1'b0;
      pcph_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == IDLE;
      exec_q  <= state_d == EXEC;
      pcph_q  <= state_d == PCUPD;
    end
  end
  // Capture the instruction fields at the handshake; the decoder may move on afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
      flag_we_q   <= 1'b0;
      br_op_q     <= '0;
      br_target_q <= '0;
    end else if (accept) begin
      rd_q        <= bus.insn_rd;
      wb_en_q     <= bus.insn_wb_en;
      flag_we_q   <= bus.insn_flag_we;
      br_op_q     <= bus.insn_br_op;
      br_target_q <= bus.insn_br_target;
    end
  end
  // Register file: only written at the end of EXEC, reset wins over the write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (state_q == EXEC && wb_en_q) begin
      regs_q[rd_q] <= bus.alu_c;
    end
  end
  // Flags update at the end of EXEC, pc at the end of PCUPD
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      pc_q    <= '0;
    end else begin
      flags_q <= flags_d;
      pc_q    <= pc_d;
    end
  end
  // Branch decision reads the flags already updated by this instruction's EXEC
  always_comb begin
    taken = (br_op_q == 2'b01 && flags_q[ALU_FLAG_EQ]) || (br_op_q == 2'b10 && flags_q[ALU_FLAG_GT]) || br_op_q == 2'b11;
  end
  assign bus.insn_ready     = ready_q;
  assign bus.phase_exec     = exec_q;
  assign bus.phase_pc       = pcph_q;
  assign bus.retire         = pcph_q && !rst;
  assign bus.pc_take_branch = pcph_q && taken;
  assign bus.pc_b_operand   = pcph_q ? (taken ? br_target_q : BIT_COUNT'(2)) : '0;
  assign bus.reg_acc        = regs_q[0];
  assign bus.reg_b          = regs_q[bus.rs_sel];
  assign bus.pc             = pc_q;
  assign bus.flags          = flags_q;
endmodule

// File: tb/tb_alu_writeback_seq.sv
// tb_alu_writeback_seq: table, corner-sequence and random checks of the writeback sequencer
module tb_alu_writeback_seq;
  localparam int BW = 8;
  localparam int FC = 2;
  localparam int EQ = 0;
  localparam int GT = 1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  alu_writeback_seq_if #(.BIT_COUNT(BW), .ALU_FLAG_COUNT(FC)) bus();
  alu_writeback_seq #(.BIT_COUNT(BW), .REG_COUNT(8), .ALU_FLAG_COUNT(FC), .ALU_FLAG_EQ(EQ), .ALU_FLAG_GT(GT))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [7:0] mregs [8];
  logic [7:0] mpc;
  logic [1:0] mflags;
  typedef struct {
    logic [2:0] rd;
    logic       wb;
    logic       fwe;
    logic [1:0] brop;
    logic [7:0] tgt;
    logic [7:0] c_exec;
    logic [1:0] fl;
    logic [7:0] c_pc;
    logic       exp_take;
    logic [7:0] exp_bop;
    logic [7:0] exp_pc;
    logic [7:0] exp_acc;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic model_reset;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mpc = 8'h00;
    mflags = 2'b00;
  endtask
  function automatic logic model_taken(input logic [1:0] op, input logic [1:0] fl);
    return (op == 2'd1 && fl[EQ]) || (op == 2'd2 && fl[GT]) || op == 2'd3;
  endfunction
  task automatic peek;
    logic [2:0] s;
    s = 3'($urandom_range(0, 7));
    bus.rs_sel = s;
    #1;
    chk("reg_b", bus.reg_b, mregs[s]);
    chk("reg_acc", bus.reg_acc, mregs[0]);
    chk("pc", bus.pc, mpc);
    chk("flags", bus.flags, mflags);
  endtask
  task automatic run_insn(input logic [2:0] rd, input logic wb, input logic fwe, input logic [1:0] brop,
                          input logic [7:0] tgt, input logic [7:0] c_exec, input logic [1:0] fl,
                          input logic [7:0] c_pc, output logic take_o, output logic [7:0] bop_o);
    logic et;
    chk("idle_ready", bus.insn_ready, 1'b1);
    chk("idle_phases", {bus.phase_exec, bus.phase_pc, bus.retire}, 3'b000);
    chk("idle_branch", {bus.pc_take_branch, bus.pc_b_operand}, 9'h0);
    bus.insn_valid = 1'b1;
    bus.insn_rd = rd;
    bus.insn_wb_en = wb;
    bus.insn_flag_we = fwe;
    bus.insn_br_op = brop;
    bus.insn_br_target = tgt;
    bus.alu_c = 8'($urandom);
    bus.alu_flags = 2'($urandom);
    peek();
    tick();
    bus.insn_valid = 1'b0;
    bus.insn_rd = 3'($urandom);
    bus.insn_wb_en = 1'($urandom);
    bus.insn_flag_we = 1'($urandom);
    bus.insn_br_op = 2'($urandom);
    bus.insn_br_target = 8'($urandom);
    bus.alu_c = c_exec;
    bus.alu_flags = fl;
    #1;
    chk("exec_phases", {bus.insn_ready, bus.phase_exec, bus.phase_pc, bus.retire}, 4'b0100);
    chk("exec_branch", {bus.pc_take_branch, bus.pc_b_operand}, 9'h0);
    tick();
    if (wb) mregs[rd] = c_exec;
    if (fwe) mflags = fl;
    bus.alu_c = c_pc;
    bus.alu_flags = 2'($urandom);
    et = model_taken(brop, mflags);
    #1;
    chk("pcupd_phases", {bus.insn_ready, bus.phase_exec, bus.phase_pc, bus.retire}, 4'b0011);
    chk("pc_take_branch", bus.pc_take_branch, et);
    chk("pc_b_operand", bus.pc_b_operand, et ? tgt : 8'h02);
    take_o = bus.pc_take_branch;
    bop_o = bus.pc_b_operand;
    peek();
    tick();
    mpc = c_pc;
    bus.alu_c = 8'($urandom);
    chk("retire_done", {bus.retire, bus.insn_ready}, 2'b01);
    chk("pc_after", bus.pc, mpc);
  endtask
  initial begin
    logic       tk;
    logic [7:0] bo;
    vecs[0] = '{3'd0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h35, 2'b00, 8'h02, 1'b0, 8'h02, 8'h02, 8'h35};
    vecs[1] = '{3'd1, 1'b0, 1'b1, 2'b01, 8'h40, 8'h11, 2'b01, 8'h40, 1'b1, 8'h40, 8'h40, 8'h35};
    vecs[2] = '{3'd0, 1'b1, 1'b1, 2'b10, 8'h77, 8'h99, 2'b01, 8'h42, 1'b0, 8'h02, 8'h42, 8'h99};
    vecs[3] = '{3'd5, 1'b1, 1'b1, 2'b10, 8'h10, 8'h12, 2'b10, 8'h10, 1'b1, 8'h10, 8'h10, 8'h99};
    vecs[4] = '{3'd0, 1'b0, 1'b0, 2'b11, 8'hF0, 8'h00, 2'b00, 8'hFE, 1'b1, 8'hF0, 8'hFE, 8'h99};
    vecs[5] = '{3'd0, 1'b0, 1'b0, 2'b00, 8'h33, 8'h5C, 2'b11, 8'h00, 1'b0, 8'h02, 8'h00, 8'h99};
    vecs[6] = '{3'd0, 1'b0, 1'b0, 2'b01, 8'h55, 8'h66, 2'b01, 8'h02, 1'b0, 8'h02, 8'h02, 8'h99};
    rst = 1'b1;
    bus.insn_valid = 1'b0;
    bus.insn_rd = '0;
    bus.insn_wb_en = 1'b0;
    bus.insn_flag_we = 1'b0;
    bus.insn_br_op = '0;
    bus.insn_br_target = '0;
    bus.rs_sel = '0;
    bus.alu_c = '0;
    bus.alu_flags = '0;
    model_reset();
    tick();
    tick();
    chk("rst_ready", bus.insn_ready, 1'b1);
    chk("rst_retire", bus.retire, 1'b0);
    chk("rst_pc_acc_flags", {bus.pc, bus.reg_acc, bus.flags}, 18'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.insn_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_hold", {bus.insn_ready, bus.phase_exec, bus.phase_pc, bus.retire}, 4'b1000);
      chk("idle_pc", bus.pc, 8'h00);
    end
    for (int i = 0; i < 7; i++) begin
      run_insn(vecs[i].rd, vecs[i].wb, vecs[i].fwe, vecs[i].brop, vecs[i].tgt, vecs[i].c_exec,
               vecs[i].fl, vecs[i].c_pc, tk, bo);
      chk("tbl_take", tk, vecs[i].exp_take);
      chk("tbl_bop", bo, vecs[i].exp_bop);
      chk("tbl_pc", bus.pc, vecs[i].exp_pc);
      chk("tbl_acc", bus.reg_acc, vecs[i].exp_acc);
    end
    bus.insn_valid = 1'b1;
    bus.insn_rd = 3'd3;
    bus.insn_wb_en = 1'b1;
    bus.insn_flag_we = 1'b1;
    bus.insn_br_op = 2'b11;
    tick();
    bus.insn_valid = 1'b0;
    bus.alu_c = 8'hAA;
    bus.alu_flags = 2'b11;
    rst = 1'b1;
    #1;
    chk("rst_exec_retire", bus.retire, 1'b0);
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_exec_state", {bus.insn_ready, bus.phase_exec, bus.phase_pc, bus.retire}, 4'b1000);
    bus.rs_sel = 3'd3;
    #1;
    chk("rst_exec_r3", bus.reg_b, 8'h00);
    chk("rst_exec_flags", bus.flags, 2'b00);
    tick();
    chk("rst_exec_idle", {bus.insn_ready, bus.retire, bus.pc}, 10'h200);
    bus.insn_valid = 1'b1;
    bus.insn_rd = 3'd2;
    bus.insn_wb_en = 1'b1;
    bus.insn_br_op = 2'b00;
    tick();
    bus.insn_valid = 1'b0;
    bus.alu_c = 8'h5A;
    tick();
    bus.alu_c = 8'h77;
    rst = 1'b1;
    #1;
    chk("rst_pcupd_retire", bus.retire, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    bus.rs_sel = 3'd2;
    #1;
    chk("rst_pcupd_r2", bus.reg_b, 8'h00);
    chk("rst_pcupd_pc", bus.pc, 8'h00);
    chk("rst_pcupd_ready", bus.insn_ready, 1'b1);
    tick();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.insn_valid = 1'b0;
        tick();
        chk("gap_idle", {bus.insn_ready, bus.retire}, 2'b10);
      end
      run_insn(3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
               2'($urandom), 8'($urandom), tk, bo);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
